// File: rtl/adc_chan_avg.sv
// adc_chan_avg: per-channel boxcar averager for MCP3208 conversion results.
//
// Every accepted 12-bit sample is added to its channel's window. When a
// channel has seen 2^LOG_N samples, the truncated mean and the window maximum
// are published for that channel and a completion strobe is raised.
//
// Ports
//   clk, rst_n       system clock; synchronous active-low reset
//   in_valid         one-cycle strobe, new result on in_chan / in_data
//   in_chan[2:0]     channel of the result
//   in_data[11:0]    unsigned conversion result
//   lb_data[31:0]    local-bus write data ([7:0] enable mask, [8] clear pulse)
//   lb_addr[6:0]     local-bus address, control register lives at LB_ADDR
//   lb_write         local-bus write strobe
//   rd_addr[3:0]     0-7 published average, 8-15 published max of rd_addr[2:0]
//   rd_data[15:0]    registered readout, zero-extended, one-cycle latency
//   out_valid        one-cycle strobe, a window just completed
//   out_chan[2:0]    channel of the completed window (held until next one)
//   out_avg[11:0]    mean of the completed window (held until next one)
//
// Handshake: in_valid, lb_write and out_valid are pure strobes with no ready
// or backpressure. Each asserted input cycle is consumed on that clock edge,
// and each out_valid cycle is one completed window.
module adc_chan_avg #(
  parameter int         LOG_N   = 4,
  parameter logic [6:0] LB_ADDR = 7'd40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [2:0]  in_chan,
  input  logic [11:0] in_data,
  input  logic [31:0] lb_data,
  input  logic [6:0]  lb_addr,
  input  logic        lb_write,
  input  logic [3:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        out_valid,
  output logic [2:0]  out_chan,
  output logic [11:0] out_avg
);

  // Accumulator is wide enough for 2^LOG_N full-scale samples.
  localparam int AW = 12 + LOG_N;
  // The sample counter needs at least one bit even when LOG_N is 0.
  localparam int CW = (LOG_N == 0) ? 1 : LOG_N;
  localparam logic [CW-1:0] LAST_CNT = CW'((1 << LOG_N) - 1);

  logic [AW-1:0] acc     [8];
  logic [CW-1:0] cnt     [8];
  logic [11:0]   run_max [8];
  logic [11:0]   avg_pub [8];
  logic [11:0]   max_pub [8];
  logic [7:0]    mask;

  logic          ctrl_wr;
  logic          clr;
  logic          accept;
  logic          last;
  logic [AW-1:0] sum;
  logic [11:0]   new_max;
  logic [11:0]   mean;

  assign ctrl_wr = lb_write && (lb_addr == LB_ADDR);
  assign clr     = ctrl_wr && lb_data[8];
  // A clear in the same cycle discards the incoming sample.
  assign accept  = in_valid && mask[in_chan] && !clr;

  // Datapath for the channel addressed by the incoming sample. The sample
  // that completes a window is folded into the mean and max directly, so
  // back-to-back samples on one channel never lose an update.
  always_comb begin
    sum     = acc[in_chan] + AW'(in_data);
    new_max = (in_data > run_max[in_chan]) ? in_data : run_max[in_chan];
    last    = (cnt[in_chan] == LAST_CNT);
    mean    = 12'(sum >> LOG_N);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        acc[i]     <= '0;
        cnt[i]     <= '0;
        run_max[i] <= '0;
        avg_pub[i] <= '0;
        max_pub[i] <= '0;
      end
      mask      <= 8'hFF;
      rd_data   <= '0;
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_avg   <= '0;
    end else begin
      out_valid <= 1'b0;

      // Readout sees the arrays as they stood before this edge.
      rd_data <= {4'b0000, rd_addr[3] ? max_pub[rd_addr[2:0]]
                                      : avg_pub[rd_addr[2:0]]};

      if (ctrl_wr) begin
        mask <= lb_data[7:0];
      end

      if (clr) begin
        for (int i = 0; i < 8; i++) begin
          acc[i]     <= '0;
          cnt[i]     <= '0;
          run_max[i] <= '0;
          avg_pub[i] <= '0;
          max_pub[i] <= '0;
        end
      end else if (accept) begin
        if (last) begin
          avg_pub[in_chan] <= mean;
          max_pub[in_chan] <= new_max;
          acc[in_chan]     <= '0;
          cnt[in_chan]     <= '0;
          run_max[in_chan] <= '0;
          out_valid        <= 1'b1;
          out_chan         <= in_chan;
          out_avg          <= mean;
        end else begin
          acc[in_chan]     <= sum;
          cnt[in_chan]     <= cnt[in_chan] + CW'(1);
          run_max[in_chan] <= new_max;
        end
      end
    end
  end

endmodule

// File: doc/adc_chan_avg.md
# adc_chan_avg

Per-channel boxcar averager downstream of the MCP3208 SPI front end. Consumes the 12-bit conversion results the front end produces, one channel-tagged strobe at a time. Accumulates 2^LOG_N samples per channel and publishes the truncated mean and the window maximum. Results are readable through a registered 4-bit address port; enables and clear are set over the local bus.

## Interface

- LOG_N, 4, log2 of samples per window; legal 0..8
- LB_ADDR, 7'd40, local-bus address of the control register

- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  one-cycle strobe: new conversion result
- in_chan  in  3  MCP3208 channel of the result
- in_data  in  12  conversion result, unsigned
- lb_data  in  32  local-bus write data
- lb_addr  in  7  local-bus address
- lb_write  in  1  local-bus write strobe
- rd_addr  in  4  readout select: 0–7 average of channel rd_addr[2:0]; 8–15 window max of channel rd_addr[2:0]
- rd_data  out  16  readout, zero-extended 12-bit value
- out_valid  out  1  one-cycle strobe: a channel's window completed
- out_chan  out  3  channel of the completed window
- out_avg  out  12  mean of the completed window

## Operation

- Per-channel state, 8 copies:
  - acc: 12+LOG_N bits; cannot overflow
  - cnt: LOG_N bits
  - run_max: 12 bits
  - avg: 12 bits, published
  - max: 12 bits, published
- Control register at LB_ADDR, written when lb_write && lb_addr==LB_ADDR:
  - lb_data[7:0]: enable mask, reset value 8'hFF
  - lb_data[8]: clear, a pulse, not stored. Zeroes acc, cnt, run_max, avg and max of all channels in the cycle after the write.
- Sample accepted when in_valid && mask[in_chan] && no clear in the same cycle. Samples on disabled channels are dropped silently; that channel's state is untouched.
- On an accepted sample for channel c:
  - If cnt[c] < 2^LOG_N−1: acc+=in_data; cnt+=1; run_max=max(run_max,in_data).
  - Otherwise the window is complete:
    - avg[c] = (acc+in_data)>>LOG_N, truncating.
    - max[c] = max(run_max,in_data).
    - acc, cnt and run_max are zeroed.
    - out_valid pulses with out_chan=c and out_avg=the new avg.
- LOG_N=0: every accepted sample completes a window; avg=max=in_data.
- Changing the mask does not reset the accumulation of a disabled channel. It resumes where it stopped when re-enabled.
- Simultaneous clear and accepted sample: clear wins and the sample is discarded.
- Mask write with clear: the new mask and the clear both take effect.

## Timing

- Reset (rst_n low at a clk edge) sets:
  - all per-channel state to 0
  - mask to 8'hFF
  - rd_data to 0
  - out_valid to 0; out_chan and out_avg to 0
- in_valid may be asserted every cycle, including back-to-back on the same channel. Each sample must be accounted with no lost update; no stall or backpressure exists.
- out_valid/out_chan/out_avg are registered: asserted the cycle after the completing in_valid, for exactly one cycle. Held values persist until the next completion.
- avg/max arrays update on the same edge that raises out_valid.
- rd_data is registered, one-cycle latency from rd_addr. A read in the cycle after an update returns the new value.
- Clear takes effect on the edge after lb_write. A sample on the next cycle starts a fresh window.
- Reset mid-window discards partial accumulation; no out_valid is produced for that window.

## Test plan

- Reset, LOG_N=4: feed ch3 samples 100,101,…,115 on consecutive cycles.
  - One out_valid, with out_chan=3 and out_avg=107.
  - rd_addr=3 reads 107; rd_addr=11 reads 115.
- Interleave ch0=4095 ×16 and ch7=0 ×16 alternately.
  - Two out_valid pulses: ch0 avg 4095, max 4095; ch7 avg 0.
  - No accumulator overflow.
- Write lb_data=32'h0000_00FE, then feed ch0 ×16 and ch1 ×16 (value 2000).
  - Only ch1 completes, avg 2000.
  - rd_addr=0 stays 0.
- Feed ch2 ×10 samples, then write clear in the same cycle as sample 11.
  - After 16 further samples of 50: out_avg=50.
  - The 10 early samples and the colliding sample are not included.
- Assert rst_n low mid-window on ch5 after 8 samples.
  - All rd_data reads 0.
  - 16 new samples of 1234 give out_avg=1234.
- LOG_N=0 build: each in_valid yields out_valid next cycle with out_avg=in_data; also check 3,4,3,4 truncation with LOG_N=1 gives 3.
